// File: rtl/light_sequence_controller.sv
// light_sequence_controller: push-button period control, blink tick, and
// GREEN -> RED -> BOTH colour schedule driving LEDG/LEDR.
// Optional feature: define LIGHT_PAUSE_EN to add a PAUSE input that freezes
// the tick/phase/mode/LED path while key handling keeps running.
module light_sequence_controller #(
  parameter int unsigned DEFAULT_PERIOD   = 25000000,
  parameter int unsigned STEP             = 12500000,
  parameter int unsigned MIN_PERIOD       = 12500000,
  parameter int unsigned MAX_PERIOD       = 250000000,
  parameter int unsigned TOGGLES_PER_MODE = 6,
  parameter int unsigned DEBOUNCE_CYCLES  = 500000
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic [2:0]  KEY,
`ifdef LIGHT_PAUSE_EN
  input  logic        PAUSE,
`endif
  output logic [31:0] PERIOD,
  output logic        TICK,
  output logic        PHASE,
  output logic [1:0]  MODE,
  output logic [7:0]  LEDG,
  output logic [9:0]  LEDR
);

  localparam int          NUM_KEYS   = 3;
  localparam int unsigned DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TOG_W      = (TOGGLES_PER_MODE > 1) ? $clog2(TOGGLES_PER_MODE) : 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(TOGGLES_PER_MODE - 1);
  localparam logic [31:0] P_DEF      = 32'(DEFAULT_PERIOD);
  localparam logic [31:0] P_STEP     = 32'(STEP);
  localparam logic [31:0] P_MIN      = 32'(MIN_PERIOD);
  localparam logic [31:0] P_MAX      = 32'(MAX_PERIOD);
  localparam logic [31:0] P_SLOW_LIM = 32'(MAX_PERIOD - STEP);
  localparam logic [31:0] P_FAST_LIM = 32'(MIN_PERIOD + STEP);

  typedef enum logic [1:0] {
    MODE_GREEN = 2'd0,
    MODE_RED   = 2'd1,
    MODE_BOTH  = 2'd2
  } mode_t;

  logic [2:0]      key_meta;
  logic [2:0]      key_sync;
  logic [2:0]      key_deb;
  logic [2:0]      key_deb_q;
  logic [DB_W-1:0] db_cnt [NUM_KEYS];
  logic [2:0]      press_c;
  logic            applied_c;
  logic            pause_c;
  logic            at_end_c;
  logic [31:0]     tick_cnt;
  logic [TOG_W-1:0] tog_cnt;
  mode_t           mode_q;

`ifdef LIGHT_PAUSE_EN
  assign pause_c = PAUSE;
`else
  assign pause_c = 1'b0;
`endif

  // Two-flop synchroniser, converting the active-low keys to active-high.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      key_meta <= '0;
      key_sync <= '0;
    end else begin
      key_meta <= ~KEY;
      key_sync <= key_meta;
    end
  end

  // Per-key debounce: flip only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      key_deb <= '0;
      for (int i = 0; i < NUM_KEYS; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (key_sync[i] == key_deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]  <= '0;
          key_deb[i] <= key_sync[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Delayed debounced level for press (rising) detection.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) key_deb_q <= '0;
    else       key_deb_q <= key_deb;
  end

  assign press_c   = key_deb & ~key_deb_q;
  assign applied_c = |press_c;
  assign at_end_c  = (tick_cnt == PERIOD - 32'd1);

  // Period register: default beats faster beats slower, all saturating.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      PERIOD <= P_DEF;
    end else if (press_c[2]) begin
      PERIOD <= P_DEF;
    end else if (press_c[1]) begin
      PERIOD <= (PERIOD >= P_FAST_LIM) ? PERIOD - P_STEP : P_MIN;
    end else if (press_c[0]) begin
      PERIOD <= (PERIOD <= P_SLOW_LIM) ? PERIOD + P_STEP : P_MAX;
    end
  end

  // Tick counter, phase and colour-mode schedule; a press restarts the period.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      tick_cnt <= '0;
      TICK     <= 1'b0;
      PHASE    <= 1'b0;
      tog_cnt  <= '0;
      mode_q   <= MODE_GREEN;
    end else if (applied_c) begin
      tick_cnt <= '0;
      TICK     <= 1'b0;
    end else if (pause_c) begin
      TICK     <= 1'b0;
    end else if (at_end_c) begin
      tick_cnt <= '0;
      TICK     <= 1'b1;
      PHASE    <= ~PHASE;
      if (tog_cnt == TOG_LAST) begin
        tog_cnt <= '0;
        case (mode_q)
          MODE_GREEN: mode_q <= MODE_RED;
          MODE_RED:   mode_q <= MODE_BOTH;
          default:    mode_q <= MODE_GREEN;
        endcase
      end else begin
        tog_cnt <= tog_cnt + TOG_W'(1);
      end
    end else begin
      tick_cnt <= tick_cnt + 32'd1;
      TICK     <= 1'b0;
    end
  end

  assign MODE = mode_q;

  // LED drive from the current phase and mode, one cycle behind them.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      LEDG <= '0;
      LEDR <= '0;
    end else if (!pause_c) begin
      LEDG <= (mode_q == MODE_GREEN || mode_q == MODE_BOTH) ? {8{PHASE}}  : 8'h00;
      LEDR <= (mode_q == MODE_RED   || mode_q == MODE_BOTH) ? {10{PHASE}} : 10'h000;
    end
  end

endmodule

// File: tb/tb_light_sequence_controller.sv
// Self-checking bench for light_sequence_controller: vector table, hand
// sequences for reset/tick corners, and randomized key bursts against a model.
module tb_light_sequence_controller;

  localparam int DEF  = 10;
  localparam int STP  = 5;
  localparam int MINP = 5;
  localparam int MAXP = 50;
  localparam int TPM  = 3;
  localparam int DB   = 4;

  logic        CLOCK_50 = 1'b0;
  logic        RESET;
  logic [2:0]  KEY;
  logic [31:0] PERIOD;
  logic        TICK;
  logic        PHASE;
  logic [1:0]  MODE;
  logic [7:0]  LEDG;
  logic [9:0]  LEDR;

  int checks   = 0;
  int failures = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  light_sequence_controller #(
    .DEFAULT_PERIOD(DEF), .STEP(STP), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP),
    .TOGGLES_PER_MODE(TPM), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET(RESET),
    .KEY(KEY),
`ifdef LIGHT_PAUSE_EN
    .PAUSE(1'b0),
`endif
    .PERIOD(PERIOD),
    .TICK(TICK),
    .PHASE(PHASE),
    .MODE(MODE),
    .LEDG(LEDG),
    .LEDR(LEDR)
  );

  // ---------------- behavioural reference model ----------------
  // Ticks are scheduled as absolute edge numbers; phase and mode are derived
  // from the total tick count; a key held DB edges yields one event 3 edges later.
  int          n;
  int          next_tick;
  int          ticks;
  int          m_period;
  bit          m_tick;
  bit          m_phase;
  int          m_mode;
  logic [7:0]  m_ledg;
  logic [9:0]  m_ledr;
  int          run [3];
  logic [2:0]  pend [int];

  function automatic int apply_ev(input int p, input logic [2:0] ev);
    if (ev[2]) return DEF;
    if (ev[1]) return (p - STP < MINP) ? MINP : p - STP;
    if (ev[0]) return (p + STP > MAXP) ? MAXP : p + STP;
    return p;
  endfunction

  task automatic model_edge();
    logic [7:0] nl_g;
    logic [9:0] nl_r;
    logic [2:0] ev;
    if (RESET) begin
      n = 0; next_tick = DEF; ticks = 0; m_period = DEF;
      m_tick = 0; m_phase = 0; m_mode = 0; m_ledg = '0; m_ledr = '0;
      for (int k = 0; k < 3; k++) run[k] = 0;
      pend.delete();
      return;
    end
    n++;
    nl_g = (m_mode == 0 || m_mode == 2) ? {8{m_phase}} : 8'h00;
    nl_r = (m_mode == 1 || m_mode == 2) ? {10{m_phase}} : 10'h000;
    for (int k = 0; k < 3; k++) begin
      if (!KEY[k]) begin
        run[k]++;
        if (run[k] == DB) begin
          if (pend.exists(n + 3)) pend[n + 3] = pend[n + 3] | 3'(1 << k);
          else                    pend[n + 3] = 3'(1 << k);
        end
      end else begin
        run[k] = 0;
      end
    end
    ev = 3'b000;
    if (pend.exists(n)) begin
      ev = pend[n];
      pend.delete(n);
    end
    if (ev != 3'b000) begin
      m_period  = apply_ev(m_period, ev);
      next_tick = n + m_period;
      m_tick    = 0;
    end else if (n == next_tick) begin
      m_tick    = 1;
      ticks++;
      next_tick = next_tick + m_period;
      m_phase   = (ticks % 2) == 1;
      m_mode    = (ticks / TPM) % 3;
    end else begin
      m_tick = 0;
    end
    m_ledg = nl_g;
    m_ledr = nl_r;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge CLOCK_50);
    model_edge();
    #1;
    check("m_period", PERIOD, 32'(m_period));
    check("m_tick",   32'(TICK),  32'(m_tick));
    check("m_phase",  32'(PHASE), 32'(m_phase));
    check("m_mode",   32'(MODE),  32'(m_mode));
    check("m_ledg",   32'(LEDG),  32'(m_ledg));
    check("m_ledr",   32'(LEDR),  32'(m_ledr));
  endtask

  task automatic press(input logic [2:0] mask, input int hold, input int gap);
    KEY = ~mask;
    for (int k = 1; k <= hold + gap; k++) begin
      cycle();
      if (k == hold) KEY = 3'b111;
    end
  endtask

  typedef struct {
    logic [2:0] mask;
    int         hold;
    int         exp_period;
    bit         applied;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int prev;
    int total;
    int early;
    int found;
    int prev_mode;
    int p;

    // Press table: key mask, hold length, expected period, event expected.
    vecs.push_back('{mask: 3'b001, hold: 20, exp_period: 15, applied: 1'b1});
    p = 15;
    for (int i = 0; i < 9; i++) begin
      p = (p + STP > MAXP) ? MAXP : p + STP;
      vecs.push_back('{mask: 3'b001, hold: 6, exp_period: p, applied: 1'b1});
    end
    vecs.push_back('{mask: 3'b100, hold: 6, exp_period: 10, applied: 1'b1});
    vecs.push_back('{mask: 3'b010, hold: 6, exp_period: 5,  applied: 1'b1});
    vecs.push_back('{mask: 3'b010, hold: 6, exp_period: 5,  applied: 1'b1});
    vecs.push_back('{mask: 3'b100, hold: 6, exp_period: 10, applied: 1'b1});
    vecs.push_back('{mask: 3'b001, hold: 3, exp_period: 10, applied: 1'b0});
    vecs.push_back('{mask: 3'b001, hold: 6, exp_period: 15, applied: 1'b1});
    vecs.push_back('{mask: 3'b001, hold: 6, exp_period: 20, applied: 1'b1});
    vecs.push_back('{mask: 3'b001, hold: 6, exp_period: 25, applied: 1'b1});
    vecs.push_back('{mask: 3'b001, hold: 6, exp_period: 30, applied: 1'b1});
    vecs.push_back('{mask: 3'b101, hold: 6, exp_period: 10, applied: 1'b1});
    vecs.push_back('{mask: 3'b011, hold: 6, exp_period: 5,  applied: 1'b1});

    // Reset state and first ticks / mode rotation.
    RESET = 1'b1;
    KEY   = 3'b111;
    cycle();
    cycle();
    check("rst_period", PERIOD, 32'd10);
    check("rst_ledg", 32'(LEDG), 32'h0);
    check("rst_ledr", 32'(LEDR), 32'h0);
    check("rst_tick", 32'(TICK), 32'h0);
    check("rst_phase", 32'(PHASE), 32'h0);
    check("rst_mode", 32'(MODE), 32'h0);
    RESET = 1'b0;
    for (int e = 1; e <= 91; e++) begin
      cycle();
      if (e == 9)  check("tick_e9", 32'(TICK), 32'h0);
      if (e == 10) begin
        check("tick_e10", 32'(TICK), 32'h1);
        check("phase_e10", 32'(PHASE), 32'h1);
      end
      if (e == 11) check("ledg_e11", 32'(LEDG), 32'hFF);
      if (e == 20) check("tick_e20", 32'(TICK), 32'h1);
      if (e == 30) begin
        check("tick_e30", 32'(TICK), 32'h1);
        check("mode_red", 32'(MODE), 32'h1);
      end
      if (e == 31) begin
        check("ledg_red", 32'(LEDG), 32'h0);
        check("ledr_red", 32'(LEDR), 32'h3FF);
      end
      if (e == 60) check("mode_both", 32'(MODE), 32'h2);
      if (e == 71) begin
        check("ledg_both", 32'(LEDG), 32'hFF);
        check("ledr_both", 32'(LEDR), 32'h3FF);
      end
      if (e == 90) check("mode_green", 32'(MODE), 32'h0);
      if (e == 91) check("ledr_green", 32'(LEDR), 32'h0);
    end

    // Table-driven presses: saturation, priority, bounce, tick restart.
    prev = DEF;
    foreach (vecs[i]) begin
      KEY   = ~vecs[i].mask;
      total = ((vecs[i].hold > DB + 3 + vecs[i].exp_period) ? vecs[i].hold
                                                            : DB + 3 + vecs[i].exp_period) + DB + 4;
      early = 0;
      for (int k = 1; k <= total; k++) begin
        cycle();
        if (k == vecs[i].hold) KEY = 3'b111;
        if (k == DB + 2) check("vec_pre", PERIOD, 32'(prev));
        if (k == DB + 3) check("vec_period", PERIOD, 32'(vecs[i].exp_period));
        if (vecs[i].applied && k >= DB + 3 && k < DB + 3 + vecs[i].exp_period && TICK === 1'b1)
          early++;
        if (vecs[i].applied && k == DB + 3 + vecs[i].exp_period)
          check("vec_tick_gap", 32'(TICK), 32'h1);
      end
      if (vecs[i].applied) check("vec_no_early_tick", 32'(early), 32'h0);
      prev = vecs[i].exp_period;
    end

    // Reset mid-count at counter=7, MODE=RED, PERIOD=40.
    press(3'b100, 6, DB + 4);
    for (int i = 0; i < 6; i++) press(3'b001, 6, DB + 4);
    check("setup_period", PERIOD, 32'd40);
    found = 0;
    prev_mode = int'(MODE);
    for (int c = 0; c < 1000; c++) begin
      cycle();
      if (TICK === 1'b1 && MODE == 2'd1 && prev_mode != 1) begin
        found = 1;
        break;
      end
      prev_mode = int'(MODE);
    end
    check("wait_red", 32'(found), 32'h1);
    for (int c = 0; c < 7; c++) cycle();
    RESET = 1'b1;
    cycle();
    check("mid_rst_period", PERIOD, 32'd10);
    check("mid_rst_mode", 32'(MODE), 32'h0);
    check("mid_rst_phase", 32'(PHASE), 32'h0);
    check("mid_rst_tick", 32'(TICK), 32'h0);
    RESET = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      cycle();
      if (e == 9)  check("post_rst_e9", 32'(TICK), 32'h0);
      if (e == 10) check("post_rst_e10", 32'(TICK), 32'h1);
    end

    // Key held through reset release: one event DB+2 cycles after release.
    RESET = 1'b1;
    KEY   = 3'b110;
    cycle();
    cycle();
    RESET = 1'b0;
    for (int e = 1; e <= 24; e++) begin
      cycle();
      if (e == DB + 2) check("held_rst_pre", PERIOD, 32'd10);
      if (e == DB + 3) check("held_rst_post", PERIOD, 32'd15);
      if (e == 12) KEY = 3'b111;
    end
    check("held_rst_once", PERIOD, 32'd15);

    // Randomized key bursts and occasional resets against the model.
    for (int r = 0; r < 60; r++) begin
      if ($urandom_range(0, 9) == 0) begin
        RESET = 1'b1;
        for (int c = 0; c < int'($urandom_range(1, 2)); c++) cycle();
        RESET = 1'b0;
      end
      press(3'($urandom_range(0, 7)), int'($urandom_range(1, DB + 6)),
            int'($urandom_range(DB + 4, 60)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/light_sequence_controller.md
Name: light_sequence_controller

Overview:
- Control block for the board's blinking-light datapath. Drives LEDG/LEDR from a programmable blink period and a three-mode colour sequence.
- Debounces the three push-buttons. Each clean press becomes exactly one period-adjust command: slower, faster or default.
- Generates the blink tick, the on/off phase and the GREEN -> RED -> BOTH mode schedule. Sits directly between the board pins and the LEDs.

Parameters:
- DEFAULT_PERIOD, 25000000: blink half-period in CLOCK_50 cycles after reset or a KEY[2] press.
- STEP, 12500000: period increment/decrement per press.
- MIN_PERIOD, 12500000: lower saturation bound. Must be >= 2.
- MAX_PERIOD, 250000000: upper saturation bound.
- TOGGLES_PER_MODE, 6: number of ticks spent in each colour mode.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed to accept a key change (10 ms).

Ports:
- CLOCK_50  input  1  sole clock; all logic on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- KEY  input  3  raw push-buttons, active-low, asynchronous to CLOCK_50. [0]=slower, [1]=faster, [2]=default.
- PERIOD  output  32  current blink half-period.
- TICK  output  1  one-cycle strobe at the end of each period.
- PHASE  output  1  current light on/off phase.
- MODE  output  2  0=GREEN, 1=RED, 2=BOTH; 3 is never produced.
- LEDG  output  8  green LEDs.
- LEDR  output  10  red LEDs.

Behaviour:
- Reset values: PERIOD=DEFAULT_PERIOD, tick counter=0, TICK=0, PHASE=0, MODE=GREEN, toggle counter=0, LEDG=0, LEDR=0. Synchronisers and debounced states reset to "released". RESET overrides every other input in the same cycle.
- Key input path: each KEY bit passes through a 2-flop synchroniser and is inverted to active-high.
- Debounce: a per-key counter counts cycles in which the synchronised level differs from the debounced level. The counter clears whenever the two agree. After DEBOUNCE_CYCLES consecutive differing cycles, the debounced level flips.
- Press event: a released->pressed transition of the debounced level is a one-cycle press event. Release transitions generate nothing. Holding a key produces exactly one event.
- Latency: if raw KEY first goes low before edge t and stays low, PERIOD shows the new value after edge t+DEBOUNCE_CYCLES+2.
- Simultaneous press events, priority order: KEY[2] (PERIOD<=DEFAULT_PERIOD) > KEY[1] > KEY[0]. Only the highest-priority action is applied.
- Slower (KEY[0]): PERIOD<=PERIOD+STEP if PERIOD <= MAX_PERIOD-STEP, else PERIOD<=MAX_PERIOD.
- Faster (KEY[1]): PERIOD<=PERIOD-STEP if PERIOD >= MIN_PERIOD+STEP, else PERIOD<=MIN_PERIOD.
- Arithmetic is 32-bit unsigned. The comparisons above make wrap-around impossible.
- Tick generator: the counter runs 0..PERIOD-1. In the cycle the counter equals PERIOD-1, TICK=1 (registered output) and the counter returns to 0. Ticks therefore occur every PERIOD cycles, the first PERIOD cycles after reset release.
- Tick restart on period change: any applied press event (even one that leaves the value unchanged) forces counter<=0 and suppresses TICK that cycle. The next tick comes PERIOD_new cycles later.
- PHASE toggles on every TICK.
- Mode FSM:
  - States GREEN -> RED -> BOTH -> GREEN.
  - The toggle counter increments on each TICK. On the TICK where the counter equals TOGGLES_PER_MODE-1, the counter returns to 0 and MODE advances.
  - PHASE toggles on that same tick.
- LED outputs (registered, so they lag PHASE/MODE by one cycle):
  - LEDG = {8{PHASE}} when MODE is GREEN or BOTH, else 0.
  - LEDR = {10{PHASE}} when MODE is RED or BOTH, else 0.
- Reset mid-operation: counters, PHASE and MODE return to reset values immediately.
- Key held through reset release: the key is debounced again from "released". One press event fires DEBOUNCE_CYCLES+2 cycles after release, and the period changes once.

Optional Feature:
- Macro: LIGHT_PAUSE_EN.
- With the macro defined:
  - Adds input port PAUSE (1 bit, synchronous to CLOCK_50, active-high).
  - While PAUSE=1, the tick counter holds, TICK=0, and PHASE, MODE, toggle counter and LEDs are frozen.
  - Key handling and PERIOD updates continue. A press during pause still zeroes the counter.
  - Counting resumes from the held value in the cycle after PAUSE falls.
- Without the macro: no PAUSE port; behaviour is as if PAUSE were tied to 0.

Test Plan:
Bench parameters: DEFAULT_PERIOD=10, STEP=5, MIN_PERIOD=5, MAX_PERIOD=50, TOGGLES_PER_MODE=3, DEBOUNCE_CYCLES=4.
1. Reset: hold RESET 2 cycles, then release -> PERIOD=10, LEDG=LEDR=0. TICK pulses at cycles 10, 20, 30 after release; PHASE=1 after the first tick; LEDG=8'hFF one cycle later.
2. Mode rotation: run 9 ticks -> MODE 0,0,0 then 1 after tick 3 (LEDG=0, LEDR follows PHASE), 2 after tick 6 (both follow PHASE), 0 after tick 9.
3. Slower with saturation: KEY[0] low 20 cycles -> PERIOD 10->15 exactly once. Eight more presses -> PERIOD 50; a further press -> stays 50 and the tick counter restarts.
4. Faster with saturation: from 10, press KEY[1] -> 5; press again -> 5. Next TICK arrives exactly 5 cycles after the update.
5. Bounce rejection and priority:
   - KEY[0] low 3 cycles then high -> PERIOD unchanged, no counter restart.
   - KEY[0] and KEY[2] pressed together while PERIOD=30 -> PERIOD=10.
   - KEY[1] and KEY[0] together at 10 -> 5.
6. Reset mid-count: assert RESET at counter=7, MODE=RED, PERIOD=40 -> next cycle PERIOD=10, MODE=GREEN, PHASE=0, first TICK 10 cycles after release.
